// File: rtl/note_duration_timer.sv
// note_duration_timer: note-length timer, done pulses every dur*clockSpeed clk cycles (optional DURATION_REMAIN_EN adds remaining output)
module note_duration_timer #(
   parameter int DUR_W   = 8,
   parameter int SPEED_W = 36
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [DUR_W-1:0]   dur,
   input  logic [SPEED_W-1:0] clockSpeed,
   output logic               done
`ifdef DURATION_REMAIN_EN
   ,
   output logic [DUR_W-1:0]   remaining
`endif
);
   localparam logic [SPEED_W-1:0] S_ONE = 1;
   localparam logic [DUR_W-1:0]   D_ONE = 1;
   logic [DUR_W-1:0]   dur_q, cnt, cnt_d;
   logic [SPEED_W-1:0] speed_q, presc, presc_d;
   logic               hold, tick, wrap, done_d;
   // next-state: restart on any input change, hold at zero while idle, otherwise cascade prescaler into unit counter
   always_comb begin
      hold    = (dur != dur_q) || (clockSpeed != speed_q) || (dur_q == '0) || (speed_q == '0);
      tick    = presc == speed_q - S_ONE;
      wrap    = tick && (cnt == dur_q - D_ONE);
      presc_d = (hold || tick) ? '0 : presc + S_ONE;
      cnt_d   = (hold || wrap) ? '0 : tick ? cnt + D_ONE : cnt;
      done_d  = !hold && wrap;
   end
   // state registers; done comes straight from a flop so it cannot glitch
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dur_q   <= '0;
         speed_q <= '0;
         presc   <= '0;
         cnt     <= '0;
         done    <= 1'b0;
      end else begin
         dur_q   <= dur;
         speed_q <= clockSpeed;
         presc   <= presc_d;
         cnt     <= cnt_d;
         done    <= done_d;
      end
   end
`ifdef DURATION_REMAIN_EN
   // units left in the current note, computed from next-state values so it reads dur on the done cycle
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) remaining <= '0;
      else remaining <= (dur == '0 || clockSpeed == '0) ? '0 : dur - cnt_d;
   end
`endif
endmodule

// File: tb/tb_note_duration_timer.sv
// tb_note_duration_timer: table-driven and scoreboard checks of note_duration_timer pulse timing
module tb_note_duration_timer;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [7:0]  dur = '0;
   logic [35:0] clock_speed = '0;
   logic        done;
`ifdef DURATION_REMAIN_EN
   logic [7:0]  remaining;
`endif
   int checks = 0;
   int errors = 0;
   int exp_q[$];

   typedef struct {
      logic [7:0]  d;
      logic [35:0] s;
      int          cycles;
      int          period;
   } vec_t;
   vec_t tbl[8];

   note_duration_timer dut (
      .clk(clk),
      .reset_n(reset_n),
      .dur(dur),
      .clockSpeed(clock_speed),
      .done(done)
`ifdef DURATION_REMAIN_EN
      ,
      .remaining(remaining)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
      end
   endtask

   // reset with inputs zeroed; returns at a falling edge with reset released
   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      dur = '0;
      clock_speed = '0;
      repeat (2) @(negedge clk);
      chk("reset_done", done, 0);
      reset_n = 1'b1;
   endtask

   // called at a falling edge just after inputs changed: next rising edge is E0 (n=0)
   task automatic observe(input int ncyc, input int period);
      int got, want;
      bit e;
      got = 0;
      want = 0;
      if (period > 0)
         for (int k = period; k < ncyc; k += period) begin
            exp_q.push_back(k);
            want++;
         end
      for (int n = 0; n < ncyc; n++) begin
         @(negedge clk);
         e = (exp_q.size() > 0) && (exp_q[0] == n);
         if (e) void'(exp_q.pop_front());
         if (done) got++;
         if (done || e) chk($sformatf("done_n%0d", n), done, e);
      end
      chk("pulse_count", got, want);
      exp_q.delete();
   endtask

   initial begin
      tbl[0] = '{8'd10,  36'd20, 450,  200};
      tbl[1] = '{8'd1,   36'd1,  20,   1};
      tbl[2] = '{8'd0,   36'd20, 1000, 0};
      tbl[3] = '{8'd10,  36'd0,  1000, 0};
      tbl[4] = '{8'd3,   36'd7,  100,  21};
      tbl[5] = '{8'd255, 36'd1,  600,  255};
      tbl[6] = '{8'd2,   36'd3,  30,   6};
      tbl[7] = '{8'd1,   36'd5,  30,   5};
      repeat (2) @(negedge clk);
      chk("reset_state_done", done, 0);
      for (int i = 0; i < 8; i++) begin
         do_reset();
         dur = tbl[i].d;
         clock_speed = tbl[i].s;
         observe(tbl[i].cycles, tbl[i].period);
      end
      // mid-period change: period of 200 abandoned, new period of 60 from E0'
      do_reset();
      dur = 8'd10;
      clock_speed = 36'd20;
      observe(150, 200);
      dur = 8'd3;
      observe(200, 60);
      // async reset between E0+199 and E0+200 kills the pending pulse
      do_reset();
      dur = 8'd10;
      clock_speed = 36'd20;
      observe(199, 200);
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1 chk("async_reset_done", done, 0);
      repeat (3) begin
         @(negedge clk);
         chk("held_reset_done", done, 0);
      end
      reset_n = 1'b1;
      observe(450, 200);
`ifdef DURATION_REMAIN_EN
      do_reset();
      dur = 8'd4;
      clock_speed = 36'd5;
      for (int n = 0; n < 45; n++) begin
         @(negedge clk);
         chk($sformatf("remaining_n%0d", n), remaining, 4 - ((n / 5) % 4));
         chk($sformatf("rem_done_n%0d", n), done, (n > 0) && (n % 20 == 0));
      end
      do_reset();
      @(negedge clk);
      chk("remaining_idle", remaining, 0);
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
